id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/id_ex_pipe_pkg.sv | 27 ++
 rtl/id_ex_pipe_operand_bypass.sv | 20 ++
 rtl/id_ex_pipe.sv | 126 ++++++++++++
 tb/tb_id_ex_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared pipeline constants, the ID/EX update-action encoding and the load-use hazard check.
package id_ex_pipe_pkg;

  localparam int unsigned DW_DEF        = 16;
  localparam int unsigned RSEL_W        = 3;
  localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;

  typedef enum logic [1:0] {
    ACT_LOAD,
    ACT_HOLD,
    ACT_BUBBLE
  } idex_act_e;

  // A load still in EX whose destination feeds the instruction now in decode.
  function automatic logic load_use_hit(
    input logic              ex_valid,
    input logic              ex_mem_read,
    input logic [RSEL_W-1:0] ex_rd_sel,
    input logic              id_valid,
    input logic [RSEL_W-1:0] id_rs_sel,
    input logic [RSEL_W-1:0] id_rt_sel
  );
    return ex_valid && ex_mem_read && id_valid &&
           ((ex_rd_sel == id_rs_sel) || (ex_rd_sel == id_rt_sel));
  endfunction

endpackage

// File: rtl/id_ex_pipe_operand_bypass.sv
// Write-through operand select: writeback data wins over the stored value on a register match.
module operand_bypass
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [RSEL_W-1:0] sel,
  input  logic [DW-1:0]     stored,
  input  logic              wb_en,
  input  logic [RSEL_W-1:0] wb_sel,
  input  logic [DW-1:0]     wb_data,
  output logic [DW-1:0]     operand
);

  always_comb begin
    operand = stored;
    if (wb_en && (wb_sel == sel)) operand = wb_data;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with write-through bypass, stall refresh and load-use bubble insertion.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int unsigned   DW        = DW_DEF,
  parameter logic [DW-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DW-1:0]     id_pc,
  input  logic [DW-1:0]     id_instr,
  input  logic [DW-1:0]     id_imm,
  input  logic [RSEL_W-1:0] id_rs_sel,
  input  logic [RSEL_W-1:0] id_rt_sel,
  input  logic [RSEL_W-1:0] id_rd_sel,
  input  logic [DW-1:0]     id_read1,
  input  logic [DW-1:0]     id_read2,
  input  logic              wb_en,
  input  logic [RSEL_W-1:0] wb_sel,
  input  logic [DW-1:0]     wb_data,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [DW-1:0]     ex_pc,
  output logic [DW-1:0]     ex_instr,
  output logic [DW-1:0]     ex_imm,
  output logic [DW-1:0]     ex_op1,
  output logic [DW-1:0]     ex_op2,
  output logic [RSEL_W-1:0] ex_rs_sel,
  output logic [RSEL_W-1:0] ex_rt_sel,
  output logic [RSEL_W-1:0] ex_rd_sel,
  output logic              hold_id
);

  logic [DW-1:0] load_op1, load_op2, hold_op1, hold_op2;
  logic          hazard;
  idex_act_e     act;

  operand_bypass #(.DW(DW)) u_load_op1 (
    .sel(id_rs_sel), .stored(id_read1), .wb_en(wb_en), .wb_sel(wb_sel),
    .wb_data(wb_data), .operand(load_op1)
  );

  operand_bypass #(.DW(DW)) u_load_op2 (
    .sel(id_rt_sel), .stored(id_read2), .wb_en(wb_en), .wb_sel(wb_sel),
    .wb_data(wb_data), .operand(load_op2)
  );

  // A stalled EX instruction must still see writes that retire while it waits.
  operand_bypass #(.DW(DW)) u_hold_op1 (
    .sel(ex_rs_sel), .stored(ex_op1), .wb_en(wb_en), .wb_sel(wb_sel),
    .wb_data(wb_data), .operand(hold_op1)
  );

  operand_bypass #(.DW(DW)) u_hold_op2 (
    .sel(ex_rt_sel), .stored(ex_op2), .wb_en(wb_en), .wb_sel(wb_sel),
    .wb_data(wb_data), .operand(hold_op2)
  );

  always_comb begin
    hazard  = load_use_hit(ex_valid, ex_mem_read, ex_rd_sel, id_valid, id_rs_sel, id_rt_sel);
    hold_id = stall || hazard;
  end

  always_comb begin
    act = ACT_LOAD;
    if (flush)                    act = ACT_BUBBLE;
    else if (stall)               act = ACT_HOLD;
    else if (hazard || !id_valid) act = ACT_BUBBLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_pc        <= '0;
      ex_instr     <= NOP_INSTR;
      ex_imm       <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_rs_sel    <= '0;
      ex_rt_sel    <= '0;
      ex_rd_sel    <= '0;
    end else begin
      case (act)
        ACT_LOAD: begin
          ex_valid     <= 1'b1;
          ex_reg_write <= id_reg_write;
          ex_mem_read  <= id_mem_read;
          ex_pc        <= id_pc;
          ex_instr     <= id_instr;
          ex_imm       <= id_imm;
          ex_op1       <= load_op1;
          ex_op2       <= load_op2;
          ex_rs_sel    <= id_rs_sel;
          ex_rt_sel    <= id_rt_sel;
          ex_rd_sel    <= id_rd_sel;
        end
        ACT_HOLD: begin
          ex_op1 <= hold_op1;
          ex_op2 <= hold_op2;
        end
        default: begin
          ex_valid     <= 1'b0;
          ex_reg_write <= 1'b0;
          ex_mem_read  <= 1'b0;
          ex_pc        <= '0;
          ex_instr     <= NOP_INSTR;
          ex_imm       <= '0;
          ex_op1       <= '0;
          ex_op2       <= '0;
          ex_rs_sel    <= '0;
          ex_rt_sel    <= '0;
          ex_rd_sel    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, bypass, load-use bubble, stall refresh, flush and reset-mid-stall.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        id_valid, id_reg_write, id_mem_read;
  logic [15:0] id_pc, id_instr, id_imm, id_read1, id_read2;
  logic [2:0]  id_rs_sel, id_rt_sel, id_rd_sel;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic [15:0] wb_data;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic [15:0] ex_pc, ex_instr, ex_imm, ex_op1, ex_op2;
  logic [2:0]  ex_rs_sel, ex_rt_sel, ex_rd_sel;
  logic        hold_id;

  int checks   = 0;
  int failures = 0;

  id_ex_pipe #(.DW(16), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_pc(id_pc), .id_instr(id_instr), .id_imm(id_imm),
    .id_rs_sel(id_rs_sel), .id_rt_sel(id_rt_sel), .id_rd_sel(id_rd_sel),
    .id_read1(id_read1), .id_read2(id_read2),
    .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_imm(ex_imm),
    .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_rs_sel(ex_rs_sel), .ex_rt_sel(ex_rt_sel), .ex_rd_sel(ex_rd_sel),
    .hold_id(hold_id)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic rw, input logic mr,
                        input logic [15:0] pc, input logic [15:0] instr, input logic [15:0] imm,
                        input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                        input logic [15:0] r1, input logic [15:0] r2);
    id_valid = v; id_reg_write = rw; id_mem_read = mr;
    id_pc = pc; id_instr = instr; id_imm = imm;
    id_rs_sel = rs; id_rt_sel = rt; id_rd_sel = rd;
    id_read1 = r1; id_read2 = r2;
  endtask

  task automatic set_wb(input logic en, input logic [2:0] sel, input logic [15:0] data);
    wb_en = en; wb_sel = sel; wb_data = data;
  endtask

  initial begin
    // Reset with random decode/writeback inputs, checked before the first edge
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_id(1'b1, 1'b1, 1'b1, 16'($urandom), 16'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom), 16'($urandom));
    set_wb(1'b1, 3'($urandom), 16'($urandom));
    #1;
    chk("rst_valid", 16'(ex_valid), 16'h0);
    chk("rst_instr", ex_instr, 16'h0800);
    chk("rst_op1", ex_op1, 16'h0);
    chk("rst_op2", ex_op2, 16'h0);
    chk("rst_hold_id", 16'(hold_id), 16'h0);
    tick(); tick();
    chk("rst_held_valid", 16'(ex_valid), 16'h0);
    chk("rst_held_instr", ex_instr, 16'h0800);
    chk("rst_held_pc", ex_pc, 16'h0);
    rst = 1'b0;

    // Bypass on op1 only
    set_id(1'b1, 1'b1, 1'b0, 16'h0010, 16'h1234, 16'hFFFE, 3'd3, 3'd4, 3'd6, 16'h1111, 16'h2222);
    set_wb(1'b1, 3'd3, 16'hABCD);
    tick();
    chk("byp_valid", 16'(ex_valid), 16'h1);
    chk("byp_reg_write", 16'(ex_reg_write), 16'h1);
    chk("byp_mem_read", 16'(ex_mem_read), 16'h0);
    chk("byp_op1", ex_op1, 16'hABCD);
    chk("byp_op2", ex_op2, 16'h2222);
    chk("byp_pc", ex_pc, 16'h0010);
    chk("byp_instr", ex_instr, 16'h1234);
    chk("byp_imm", ex_imm, 16'hFFFE);
    chk("byp_rs", 16'(ex_rs_sel), 16'h3);
    chk("byp_rt", 16'(ex_rt_sel), 16'h4);
    chk("byp_rd", 16'(ex_rd_sel), 16'h6);

    // Both sources bypassed from register 0; then matching select with wb_en low
    set_id(1'b1, 1'b0, 1'b0, 16'h0012, 16'h1300, 16'h0001, 3'd0, 3'd0, 3'd1, 16'h0AAA, 16'h0BBB);
    set_wb(1'b1, 3'd0, 16'h5A5A);
    tick();
    chk("byp_both_op1", ex_op1, 16'h5A5A);
    chk("byp_both_op2", ex_op2, 16'h5A5A);
    set_id(1'b1, 1'b0, 1'b0, 16'h0014, 16'h1400, 16'h0002, 3'd2, 3'd2, 3'd1, 16'h0CCC, 16'h0DDD);
    set_wb(1'b0, 3'd2, 16'h9999);
    tick();
    chk("nobyp_op1", ex_op1, 16'h0CCC);
    chk("nobyp_op2", ex_op2, 16'h0DDD);

    // Load-use: load with rd=5 in EX, consumer reads r5 through rt
    set_id(1'b1, 1'b1, 1'b1, 16'h0020, 16'h2000, 16'h0004, 3'd1, 3'd2, 3'd5, 16'h0001, 16'h0002);
    set_wb(1'b0, 3'd0, 16'h0000);
    tick();
    chk("lu_ex_mem_read", 16'(ex_mem_read), 16'h1);
    chk("lu_ex_rd", 16'(ex_rd_sel), 16'h5);
    set_id(1'b1, 1'b1, 1'b0, 16'h0022, 16'h3000, 16'h0006, 3'd1, 3'd5, 3'd7, 16'h4444, 16'h5555);
    #1;
    chk("lu_hold_id", 16'(hold_id), 16'h1);
    id_valid = 1'b0;
    #1;
    chk("lu_invalid_no_hold", 16'(hold_id), 16'h0);
    id_valid = 1'b1;
    tick();
    chk("lu_bubble_valid", 16'(ex_valid), 16'h0);
    chk("lu_bubble_instr", ex_instr, 16'h0800);
    chk("lu_bubble_mem_read", 16'(ex_mem_read), 16'h0);
    chk("lu_bubble_reg_write", 16'(ex_reg_write), 16'h0);
    chk("lu_hold_released", 16'(hold_id), 16'h0);
    tick();
    chk("lu_reload_valid", 16'(ex_valid), 16'h1);
    chk("lu_reload_rt", 16'(ex_rt_sel), 16'h5);
    chk("lu_reload_instr", ex_instr, 16'h3000);
    chk("lu_reload_op2", ex_op2, 16'h5555);

    // Load-use through rs
    set_id(1'b1, 1'b0, 1'b1, 16'h0024, 16'h2100, 16'h0000, 3'd0, 3'd0, 3'd3, 16'h0, 16'h0);
    tick();
    set_id(1'b1, 1'b0, 1'b0, 16'h0026, 16'h3100, 16'h0000, 3'd3, 3'd6, 3'd4, 16'h0, 16'h0);
    #1;
    chk("lu_rs_hold_id", 16'(hold_id), 16'h1);

    // Stall refresh of held operands
    set_id(1'b1, 1'b1, 1'b0, 16'h0040, 16'h4000, 16'h0008, 3'd2, 3'd7, 3'd3, 16'h0102, 16'h0304);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("st_load_op1", ex_op1, 16'h0102);
    stall = 1'b1;
    set_id(1'b1, 1'b0, 1'b1, 16'hDEAD, 16'hDEAD, 16'hDEAD, 3'd6, 3'd6, 3'd6, 16'hDEAD, 16'hDEAD);
    set_wb(1'b1, 3'd2, 16'h00FF);
    #1;
    chk("st_hold_id", 16'(hold_id), 16'h1);
    tick();
    chk("st_ref_op1", ex_op1, 16'h00FF);
    chk("st_keep_op2", ex_op2, 16'h0304);
    chk("st_keep_pc", ex_pc, 16'h0040);
    chk("st_keep_instr", ex_instr, 16'h4000);
    chk("st_keep_imm", ex_imm, 16'h0008);
    chk("st_keep_valid", 16'(ex_valid), 16'h1);
    chk("st_keep_reg_write", 16'(ex_reg_write), 16'h1);
    chk("st_keep_rs", 16'(ex_rs_sel), 16'h2);
    set_wb(1'b1, 3'd7, 16'h7777);
    tick();
    chk("st_ref_op2", ex_op2, 16'h7777);
    chk("st_keep_op1", ex_op1, 16'h00FF);

    // Flush beats stall
    flush = 1'b1;
    tick();
    chk("fl_valid", 16'(ex_valid), 16'h0);
    chk("fl_instr", ex_instr, 16'h0800);
    chk("fl_op1", ex_op1, 16'h0);
    chk("fl_pc", ex_pc, 16'h0);
    flush = 1'b0; stall = 1'b0;

    // id_valid low on a load edge gives a bubble
    set_id(1'b0, 1'b1, 1'b1, 16'h0050, 16'h5500, 16'h0001, 3'd1, 3'd1, 3'd1, 16'h1, 16'h1);
    set_wb(1'b0, 3'd0, 16'h0);
    tick();
    chk("inv_valid", 16'(ex_valid), 16'h0);
    chk("inv_reg_write", 16'(ex_reg_write), 16'h0);
    chk("inv_mem_read", 16'(ex_mem_read), 16'h0);

    // Reset pulsed between edges while stalled
    set_id(1'b1, 1'b1, 1'b0, 16'h0058, 16'h5000, 16'h0003, 3'd1, 3'd2, 3'd3, 16'h1234, 16'h5678);
    tick();
    chk("rs_pre_valid", 16'(ex_valid), 16'h1);
    stall = 1'b1;
    tick();
    #1 rst = 1'b1;
    #1;
    chk("rs_async_valid", 16'(ex_valid), 16'h0);
    chk("rs_async_instr", ex_instr, 16'h0800);
    chk("rs_async_op1", ex_op1, 16'h0);
    chk("rs_async_reg_write", 16'(ex_reg_write), 16'h0);
    rst = 1'b0;
    stall = 1'b0;
    set_id(1'b1, 1'b1, 1'b0, 16'h0060, 16'h6000, 16'h0007, 3'd4, 3'd5, 3'd6, 16'h0A0A, 16'h0B0B);
    tick();
    chk("rs_after_valid", 16'(ex_valid), 16'h1);
    chk("rs_after_instr", ex_instr, 16'h6000);
    chk("rs_after_pc", ex_pc, 16'h0060);
    chk("rs_after_op1", ex_op1, 16'h0A0A);
    chk("rs_after_op2", ex_op2, 16'h0B0B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
